lc4_divider_seq: RTL

LC4_DIVIDER_SEQ -- requirements
Module: lc4_divider_seq

---
 rtl/lc4_divider_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/lc4_divider_seq.sv
// Sequential 16-bit unsigned restoring divider with valid/ready request side and
// valid/ack result side. Fixed latency of 16 iteration cycles after accept.
module lc4_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ack,
  output logic [15:0] o_quotient,
  output logic [15:0] o_remainder
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [15:0] div_q;
  logic [15:0] dvs_q;
  logic [15:0] rem_q;
  logic [15:0] quo_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic [15:0] quotient_q;
  logic [15:0] remainder_q;

  logic [15:0] shifted;
  logic        take;
  logic [15:0] rem_step;
  logic [15:0] quo_step;

  // rem_q[15] is the bit shifted out of the 16-bit window; when set the true
  // partial remainder exceeds any divisor, and the wrapped 16-bit difference is exact.
  always_comb begin
    shifted  = {rem_q[14:0], div_q[15]};
    take     = rem_q[15] | (shifted >= dvs_q);
    rem_step = take ? (shifted - dvs_q) : shifted;
    quo_step = {quo_q[14:0], take};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            div_q   <= i_dividend;
            dvs_q   <= i_divisor;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          div_q <= {div_q[14:0], 1'b0};
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Divide-by-zero reports 0/0 rather than the raw all-ones quotient.
            quotient_q  <= (dvs_q == 16'd0) ? 16'd0 : quo_step;
            remainder_q <= (dvs_q == 16'd0) ? 16'd0 : rem_step;
            valid_q     <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (i_ack) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;

endmodule
